gate_input_debounce: RTL and testbench
======================================

Name: gate_input_debounce

Overview:
- Two-channel input conditioner that sits directly upstream of the two-input logic gate blocks (nand, nor, xor and similar). Board switches/buttons enter here, and the clean levels drive gate inputs `a` and `b`.
- Per channel:
  - a 2-flop synchroniser into the `clk` domain;
  - a counter-based debounce state machine;
  - a one-cycle edge pulse, so downstream logic and LEDs see glitch-free, stable levels.

Parameters:
- CNT_MAX, 1000000, consecutive stable synchronised samples needed to accept a level change (10 ms at 100 MHz). Legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each channel's debounce counter.

Ports:
- clk  input  1  system clock. The only clock.
- rst_n  input  1  asynchronous, active-low reset.
- sw_a  input  1  raw, asynchronous, bouncing switch for channel A.
- sw_b  input  1  raw, asynchronous, bouncing switch for channel B.
- a  output  1  debounced level of sw_a. Feeds gate input a.
- b  output  1  debounced level of sw_b. Feeds gate input b.
- a_rise  output  1  one-cycle pulse when `a` goes 0->1.
- a_fall  output  1  one-cycle pulse when `a` goes 1->0.
- b_rise  output  1  one-cycle pulse when `b` goes 0->1.
- b_fall  output  1  one-cycle pulse when `b` goes 1->0.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- While `rst_n`=0:
  - all synchroniser flops, counters and FSM state are cleared;
  - `a`, `b`, `a_rise`, `a_fall`, `b_rise`, `b_fall` are all 0.
  - The reset takes effect immediately, independent of `clk`. It releases synchronously on the next `clk` rising edge.
- Channels are fully independent and identical. Channel A is described; B is the same.
- Synchroniser:
  - two flops, `sync1` <= `sw_a`, then `sync2` <= `sync1`;
  - only `sync2` feeds the FSM;
  - `sw_a` is never used combinationally.
- FSM states: S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L. Reset state is S_LOW.
  - S_LOW (`a`=0):
    - `sync2`=1 -> S_WAIT_H, cnt=1;
    - otherwise stay, cnt=0.
  - S_WAIT_H (`a`=0):
    - `sync2`=0 -> S_LOW, cnt=0 (bounce rejected);
    - `sync2`=1 and cnt==CNT_MAX-1 -> S_HIGH, `a`<=1, `a_rise`<=1 for exactly one cycle, cnt=0;
    - otherwise cnt<=cnt+1.
  - S_HIGH (`a`=1):
    - `sync2`=0 -> S_WAIT_L, cnt=1;
    - otherwise stay.
  - S_WAIT_L (`a`=1):
    - `sync2`=1 -> S_HIGH, cnt=0;
    - `sync2`=0 and cnt==CNT_MAX-1 -> S_LOW, `a`<=0, `a_fall`<=1 for one cycle, cnt=0;
    - otherwise cnt<=cnt+1.
- Latency:
  - If `sw_a` is first sampled high at edge E0 and stays high, `a` becomes 1 after edge E0+CNT_MAX+1.
  - `a_rise` is high for the single cycle following that edge.
  - The falling direction is symmetric.
- Glitch rejection: a pulse on `sw_a` shorter than CNT_MAX clock periods (after synchronisation) never changes `a` and produces no edge pulse.
- Counter width:
  - the counter never exceeds CNT_MAX-1, so it never wraps;
  - cnt is held at 0 in the S_LOW and S_HIGH states.
- Outputs:
  - all outputs are registered, with no combinational path from any input;
  - `a_rise` and `a_fall` are never high in the same cycle;
  - the next edge pulse is at least CNT_MAX cycles after the previous one.
- Simultaneous events:
  - A and B may change state, and pulse, in the same cycle;
  - there is no interaction between channels.
- Reset mid-count: asserting `rst_n` during S_WAIT_H or S_WAIT_L aborts the count. After release the channel restarts from S_LOW with cnt=0, even if `sw_a` is still high. It then re-qualifies a high level with the full latency.

Test Plan (CNT_MAX=4, CNT_W=3):
1. Reset release with `sw_a`=`sw_b`=0, run 20 cycles -> `a`=`b`=0 and all pulses 0 throughout.
2. `sw_a` 0->1 before edge 10, held -> `a`=1 after edge 15. `a_rise`=1 for exactly one cycle after edge 15. `b` and the B pulses are unchanged.
3. Bounce: `sw_a` high 2 cycles, low 1, high 3, low (starting from `a`=0) -> `a` stays 0 and `a_rise` is never asserted.
4. `a`=1, then `sw_a` 1->0 held -> `a`=0 exactly 5 edges after the first low sample. `a_fall` is a single-cycle pulse.
5. `sw_a` and `sw_b` rise in the same cycle -> `a` and `b` go high after the same edge, and `a_rise` and `b_rise` pulse together.
6. `sw_a` high for 3 synchronised cycles (mid-count), then `rst_n`=0 asynchronously between edges -> all outputs go 0 immediately. After release with `sw_a` still high, `a` goes high CNT_MAX+1 edges after the first post-reset sample.

Source files
------------

// File: rtl/gate_input_debounce_if.sv
// gate_input_debounce_if: raw switch inputs and debounced gate-input levels with edge pulses
interface gate_input_debounce_if;
    logic sw_a;
    logic sw_b;
    logic a;
    logic b;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
    modport master (output sw_a, sw_b, input a, b, a_rise, a_fall, b_rise, b_fall);
    modport slave  (input sw_a, sw_b, output a, b, a_rise, a_fall, b_rise, b_fall);
endinterface

// File: rtl/gate_input_debounce.sv
// gate_input_debounce: two-channel synchronise, debounce and edge-detect feeding gate inputs a/b
module gate_input_debounce #(
    parameter int CNT_MAX = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_input_debounce_if.slave io
);
    typedef enum logic [1:0] {S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT_MAX - 1);
    logic [1:0] sw;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
    assign sw        = {io.sw_b, io.sw_a};
    assign io.a      = lvl[0];
    assign io.b      = lvl[1];
    assign io.a_rise = rise[0];
    assign io.a_fall = fall[0];
    assign io.b_rise = rise[1];
    assign io.b_fall = fall[1];
    for (genvar i = 0; i < 2; i++) begin : g_ch
        state_t           st;
        state_t           st_nx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;
        logic             sync1;
        logic             sync2;
        logic             lvl_q;
        logic             rise_q;
        logic             fall_q;
        logic             rise_nx;
        logic             fall_nx;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                st     <= S_LOW;
                cnt    <= '0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync1  <= sw[i];
                sync2  <= sync1;
                st     <= st_nx;
                cnt    <= cnt_nx;
                lvl_q  <= st_nx == S_HIGH || st_nx == S_WAIT_L;
                rise_q <= rise_nx;
                fall_q <= fall_nx;
            end
        end
        // Counter only runs in the WAIT states, so it is cleared on every path out of them
        always_comb begin
            st_nx   = st;
            cnt_nx  = '0;
            rise_nx = 1'b0;
            fall_nx = 1'b0;
            case (st)
                S_LOW: begin
                    if (sync2) begin
                        st_nx  = S_WAIT_H;
                        cnt_nx = CNT_W'(1);
                    end
                end
                S_WAIT_H: begin
                    if (!sync2) begin
                        st_nx = S_LOW;
                    end else if (cnt == LAST) begin
                        st_nx   = S_HIGH;
                        rise_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!sync2) begin
                        st_nx  = S_WAIT_L;
                        cnt_nx = CNT_W'(1);
                    end
                end
                S_WAIT_L: begin
                    if (sync2) begin
                        st_nx = S_HIGH;
                    end else if (cnt == LAST) begin
                        st_nx   = S_LOW;
                        fall_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: st_nx = S_LOW;
            endcase
        end
        assign lvl[i]  = lvl_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
    end
endmodule

// File: tb/tb_gate_input_debounce.sv
// tb_gate_input_debounce: scoreboard bench for the two-channel debouncer at CNT_MAX=4
module tb_gate_input_debounce;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    logic [5:0] sb[$];
    logic [5:0] obs;
    gate_input_debounce_if bus ();
    gate_input_debounce #(.CNT_MAX(4), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));
    always #5 clk = ~clk;
    // {a, b, a_rise, a_fall, b_rise, b_fall}
    assign obs = {bus.a, bus.b, bus.a_rise, bus.a_fall, bus.b_rise, bus.b_fall};

    task automatic test_reset();
        logic [5:0] e;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(6'b000000);
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL reset_hold got=%b exp=%b", obs, e); else n_pass++;
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            sb.push_back(6'b000000);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL reset_idle k=%0d got=%b exp=%b", k, obs, e); else n_pass++;
        end
    endtask

    task automatic test_rise();
        logic [5:0] e;
        for (int k = 1; k <= 8; k++) begin
            bus.sw_a = 1'b1;
            sb.push_back({k >= 6, 1'b0, k == 6, 1'b0, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL rise k=%0d got=%b exp=%b", k, obs, e); else n_pass++;
        end
    endtask

    task automatic test_fall();
        logic [5:0] e;
        for (int k = 1; k <= 8; k++) begin
            bus.sw_a = 1'b0;
            sb.push_back({k < 6, 1'b0, 1'b0, k == 6, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL fall k=%0d got=%b exp=%b", k, obs, e); else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [5:0] e;
        for (int k = 1; k <= 14; k++) begin
            bus.sw_a = k <= 2 || (k >= 4 && k <= 6);
            sb.push_back(6'b000000);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL bounce k=%0d got=%b exp=%b", k, obs, e); else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] e;
        for (int k = 1; k <= 8; k++) begin
            bus.sw_a = 1'b1;
            bus.sw_b = 1'b1;
            sb.push_back({k >= 6, k >= 6, k == 6, 1'b0, k == 6, 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL simul k=%0d got=%b exp=%b", k, obs, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_count();
        logic [5:0] e;
        for (int k = 1; k <= 8; k++) begin
            bus.sw_a = 1'b0;
            sb.push_back({k < 6, 1'b1, 1'b0, k == 6, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL mid_setup k=%0d got=%b exp=%b", k, obs, e); else n_pass++;
        end
        for (int k = 1; k <= 5; k++) begin
            bus.sw_a = 1'b1;
            sb.push_back(6'b010000);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL mid_count k=%0d got=%b exp=%b", k, obs, e); else n_pass++;
        end
        #2 rst_n = 1'b0;
        sb.push_back(6'b000000);
        #1;
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL mid_async_reset got=%b exp=%b", obs, e); else n_pass++;
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            sb.push_back({k >= 6, k >= 6, k == 6, 1'b0, k == 6, 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL mid_requal k=%0d got=%b exp=%b", k, obs, e); else n_pass++;
        end
    endtask

    initial begin
        bus.sw_a = 1'b0;
        bus.sw_b = 1'b0;
        test_reset();
        test_rise();
        test_fall();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule
